// File: rtl/sriz_mem_arbiter.sv
// rtl/sriz_mem_arbiter.sv - round-robin IFU/LSU arbiter for the fixed-latency core data-memory port
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-low reset
//   ifu_req_valid/ready       IFU fetch request handshake, ifu_addr fetch address
//   ifu_resp_valid/rdata      one-cycle fetch response pulse and held fetch data
//   lsu_req_valid/ready       LSU request handshake with lsu_wen/size/addr/wdata
//   lsu_resp_valid/rdata      one-cycle load/store response pulse and held load data
//   mem_req/wen/size/addr/wdata  memory access strobe and fields
//   mem_rdata                 memory read data, valid LATENCY cycles after mem_req

module sriz_mem_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ifu_req_valid,
   output logic              ifu_req_ready,
   input  logic [ADDR_W-1:0] ifu_addr,
   output logic              ifu_resp_valid,
   output logic [DATA_W-1:0] ifu_rdata,
   input  logic              lsu_req_valid,
   output logic              lsu_req_ready,
   input  logic              lsu_wen,
   input  logic [1:0]        lsu_size,
   input  logic [ADDR_W-1:0] lsu_addr,
   input  logic [DATA_W-1:0] lsu_wdata,
   output logic              lsu_resp_valid,
   output logic [DATA_W-1:0] lsu_rdata,
   output logic              mem_req,
   output logic              mem_wen,
   output logic [1:0]        mem_size,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   localparam logic [3:0] WAIT_LOAD = 4'(LATENCY - 1);
   localparam logic [1:0] SIZE_WORD = 2'b10;

   state_t            state_q, state_d;
   logic              owner_lsu_q, owner_lsu_d;
   logic              last_lsu_q, last_lsu_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_wen_q, mem_wen_d;
   logic [1:0]        mem_size_q, mem_size_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic              ifu_resp_valid_q, ifu_resp_valid_d;
   logic              lsu_resp_valid_q, lsu_resp_valid_d;
   logic [DATA_W-1:0] ifu_rdata_q, ifu_rdata_d;
   logic [DATA_W-1:0] lsu_rdata_q, lsu_rdata_d;
   logic              in_idle;

   // Ready is gated by reset so every output reads 0 while rst is low.
   assign in_idle       = rst & (state_q == S_IDLE);
   // On a tie the requester that did not win last time gets the port.
   assign ifu_req_ready = in_idle & ifu_req_valid & (~lsu_req_valid | last_lsu_q);
   assign lsu_req_ready = in_idle & lsu_req_valid & (~ifu_req_valid | ~last_lsu_q);

   always_comb begin
      state_d          = state_q;
      owner_lsu_d      = owner_lsu_q;
      last_lsu_d       = last_lsu_q;
      cnt_d            = cnt_q;
      mem_req_d        = 1'b0;
      mem_wen_d        = mem_wen_q;
      mem_size_d       = mem_size_q;
      mem_addr_d       = mem_addr_q;
      mem_wdata_d      = mem_wdata_q;
      ifu_resp_valid_d = 1'b0;
      lsu_resp_valid_d = 1'b0;
      ifu_rdata_d      = ifu_rdata_q;
      lsu_rdata_d      = lsu_rdata_q;
      case (state_q)
         S_IDLE: begin
            if (ifu_req_ready) begin
               owner_lsu_d = 1'b0;
               last_lsu_d  = 1'b0;
               mem_wen_d   = 1'b0;
               mem_size_d  = SIZE_WORD;
               mem_addr_d  = ifu_addr;
               mem_wdata_d = '0;
               mem_req_d   = 1'b1;
               state_d     = S_ISSUE;
            end else if (lsu_req_ready) begin
               owner_lsu_d = 1'b1;
               last_lsu_d  = 1'b1;
               mem_wen_d   = lsu_wen;
               mem_size_d  = lsu_size;
               mem_addr_d  = lsu_addr;
               mem_wdata_d = lsu_wdata;
               mem_req_d   = 1'b1;
               state_d     = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = WAIT_LOAD;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               // Data lands straight in the owner's rdata register so it
               // is visible together with the response pulse in RESP.
               if (owner_lsu_q) begin
                  lsu_resp_valid_d = 1'b1;
                  lsu_rdata_d      = mem_wen_q ? '0 : mem_rdata;
               end else begin
                  ifu_resp_valid_d = 1'b1;
                  ifu_rdata_d      = mem_rdata;
               end
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            mem_wen_d   = 1'b0;
            mem_size_d  = 2'b00;
            mem_addr_d  = '0;
            mem_wdata_d = '0;
            state_d     = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q          <= S_IDLE;
         owner_lsu_q      <= 1'b0;
         last_lsu_q       <= 1'b0;
         cnt_q            <= 4'd0;
         mem_req_q        <= 1'b0;
         mem_wen_q        <= 1'b0;
         mem_size_q       <= 2'b00;
         mem_addr_q       <= '0;
         mem_wdata_q      <= '0;
         ifu_resp_valid_q <= 1'b0;
         lsu_resp_valid_q <= 1'b0;
         ifu_rdata_q      <= '0;
         lsu_rdata_q      <= '0;
      end else begin
         state_q          <= state_d;
         owner_lsu_q      <= owner_lsu_d;
         last_lsu_q       <= last_lsu_d;
         cnt_q            <= cnt_d;
         mem_req_q        <= mem_req_d;
         mem_wen_q        <= mem_wen_d;
         mem_size_q       <= mem_size_d;
         mem_addr_q       <= mem_addr_d;
         mem_wdata_q      <= mem_wdata_d;
         ifu_resp_valid_q <= ifu_resp_valid_d;
         lsu_resp_valid_q <= lsu_resp_valid_d;
         ifu_rdata_q      <= ifu_rdata_d;
         lsu_rdata_q      <= lsu_rdata_d;
      end
   end

   assign mem_req        = mem_req_q;
   assign mem_wen        = mem_wen_q;
   assign mem_size       = mem_size_q;
   assign mem_addr       = mem_addr_q;
   assign mem_wdata      = mem_wdata_q;
   assign ifu_resp_valid = ifu_resp_valid_q;
   assign lsu_resp_valid = lsu_resp_valid_q;
   assign ifu_rdata      = ifu_rdata_q;
   assign lsu_rdata      = lsu_rdata_q;

endmodule

// File: tb/tb_sriz_mem_arbiter.sv
// tb/tb_sriz_mem_arbiter.sv - bench for sriz_mem_arbiter at LATENCY 1 (instance 0) and 4 (instance 1)

module tb_sriz_mem_arbiter;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        ifu_v [2];
   logic [31:0] ifu_a [2];
   logic        ifu_rdy [2];
   logic        ifu_rv [2];
   logic [31:0] ifu_rd [2];
   logic        lsu_v [2];
   logic        lsu_we [2];
   logic [1:0]  lsu_sz [2];
   logic [31:0] lsu_a [2];
   logic [31:0] lsu_wd [2];
   logic        lsu_rdy [2];
   logic        lsu_rv [2];
   logic [31:0] lsu_rd [2];
   logic        m_req [2];
   logic        m_we [2];
   logic [1:0]  m_sz [2];
   logic [31:0] m_a [2];
   logic [31:0] m_wd [2];
   logic [31:0] mrd [2];

   for (genvar g = 0; g < 2; g++) begin : g_dut
      sriz_mem_arbiter #(
         .ADDR_W (32),
         .DATA_W (32),
         .LATENCY(g == 0 ? 1 : 4)
      ) u_dut (
         .clk           (clk),
         .rst           (rst),
         .ifu_req_valid (ifu_v[g]),
         .ifu_req_ready (ifu_rdy[g]),
         .ifu_addr      (ifu_a[g]),
         .ifu_resp_valid(ifu_rv[g]),
         .ifu_rdata     (ifu_rd[g]),
         .lsu_req_valid (lsu_v[g]),
         .lsu_req_ready (lsu_rdy[g]),
         .lsu_wen       (lsu_we[g]),
         .lsu_size      (lsu_sz[g]),
         .lsu_addr      (lsu_a[g]),
         .lsu_wdata     (lsu_wd[g]),
         .lsu_resp_valid(lsu_rv[g]),
         .lsu_rdata     (lsu_rd[g]),
         .mem_req       (m_req[g]),
         .mem_wen       (m_we[g]),
         .mem_size      (m_sz[g]),
         .mem_addr      (m_a[g]),
         .mem_wdata     (m_wd[g]),
         .mem_rdata     (mrd[g])
      );
   end

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;

   // Transaction-level reference: an access handshaken at cycle t issues at
   // t+1, samples memory at t+1+L, responds at t+2+L, frees the port at t+3+L.
   bit          busy [2];
   int          t_hs [2];
   bit          own_lsu [2];
   bit          lg_lsu [2];
   logic [31:0] e_addr [2];
   logic [31:0] e_wd [2];
   bit          e_we [2];
   logic [1:0]  e_sz [2];
   logic [31:0] cap [2];
   logic [31:0] ifu_hold [2];
   logic [31:0] lsu_hold [2];
   bit          hs_ifu [2];
   bit          hs_lsu [2];
   bit          rd_fix [2];

   int obs_ifu_hs [2];
   int obs_mreq [2];
   int obs_ifu_rv [2];
   int g_cyc [$];
   bit g_lsu [$];

   task automatic chk(string tag, int i, logic [31:0] obs, logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s inst%0d cyc=%0d observed=%h expected=%h", tag, i, cyc, obs, exp);
      end
   endtask

   task automatic check_inst(int i);
      int L;
      bit ir, lr, mq, iv, lv;
      L = (i == 0) ? 1 : 4;
      if (!rst) begin
         busy[i] = 0; lg_lsu[i] = 0; ifu_hold[i] = '0; lsu_hold[i] = '0;
      end
      if (busy[i] && cyc >= t_hs[i] + 3 + L) busy[i] = 0;
      ir = rst && !busy[i] && ifu_v[i] && (!lsu_v[i] || lg_lsu[i]);
      lr = rst && !busy[i] && lsu_v[i] && (!ifu_v[i] || !lg_lsu[i]);
      mq = busy[i] && (cyc == t_hs[i] + 1);
      iv = 0; lv = 0;
      if (busy[i] && cyc == t_hs[i] + 2 + L) begin
         if (own_lsu[i]) begin lv = 1; lsu_hold[i] = cap[i]; end
         else begin iv = 1; ifu_hold[i] = cap[i]; end
      end
      chk("ifu_req_ready", i, ifu_rdy[i], ir);
      chk("lsu_req_ready", i, lsu_rdy[i], lr);
      chk("mem_req", i, m_req[i], mq);
      chk("mem_wen", i, m_we[i], busy[i] ? e_we[i] : 1'b0);
      chk("mem_size", i, m_sz[i], busy[i] ? e_sz[i] : 2'b00);
      chk("mem_addr", i, m_a[i], busy[i] ? e_addr[i] : 32'h0);
      chk("mem_wdata", i, m_wd[i], busy[i] ? e_wd[i] : 32'h0);
      chk("ifu_resp_valid", i, ifu_rv[i], iv);
      chk("ifu_rdata", i, ifu_rd[i], ifu_hold[i]);
      chk("lsu_resp_valid", i, lsu_rv[i], lv);
      chk("lsu_rdata", i, lsu_rd[i], lsu_hold[i]);
      if (busy[i] && cyc == t_hs[i] + 1 + L) cap[i] = e_we[i] ? 32'h0 : mrd[i];
      if (ifu_rdy[i] && ifu_v[i]) begin
         obs_ifu_hs[i]++;
         if (i == 0) begin g_cyc.push_back(cyc); g_lsu.push_back(1'b0); end
      end
      if (lsu_rdy[i] && lsu_v[i] && i == 0) begin g_cyc.push_back(cyc); g_lsu.push_back(1'b1); end
      if (m_req[i]) obs_mreq[i]++;
      if (ifu_rv[i]) obs_ifu_rv[i]++;
      if (ir) begin
         busy[i] = 1; t_hs[i] = cyc; own_lsu[i] = 0; lg_lsu[i] = 0; hs_ifu[i] = 1;
         e_addr[i] = ifu_a[i]; e_we[i] = 0; e_sz[i] = 2'b10; e_wd[i] = '0;
      end else if (lr) begin
         busy[i] = 1; t_hs[i] = cyc; own_lsu[i] = 1; lg_lsu[i] = 1; hs_lsu[i] = 1;
         e_addr[i] = lsu_a[i]; e_we[i] = lsu_we[i]; e_sz[i] = lsu_sz[i]; e_wd[i] = lsu_wd[i];
      end
   endtask

   task automatic tick();
      @(negedge clk);
      check_inst(0);
      check_inst(1);
      @(posedge clk);
      #1;
      cyc++;
      for (int i = 0; i < 2; i++) if (!rd_fix[i]) mrd[i] = $urandom;
   endtask

   task automatic clear_inputs();
      for (int i = 0; i < 2; i++) begin
         ifu_v[i] = 0; ifu_a[i] = '0; lsu_v[i] = 0; lsu_we[i] = 0;
         lsu_sz[i] = 2'b00; lsu_a[i] = '0; lsu_wd[i] = '0;
      end
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 0;
      tick();
      tick();
      rst = 1;
   endtask

   task automatic wait_hs(int i, bit lsu_side);
      int n = 0;
      hs_ifu[i] = 0; hs_lsu[i] = 0;
      while (!(lsu_side ? hs_lsu[i] : hs_ifu[i]) && n < 40) begin tick(); n++; end
      chk(lsu_side ? "lsu_handshake_seen" : "ifu_handshake_seen", i,
          lsu_side ? hs_lsu[i] : hs_ifu[i], 1'b1);
      if (lsu_side) lsu_v[i] = 0; else ifu_v[i] = 0;
   endtask

   task automatic rand_drive(int i);
      if (ifu_v[i] && !hs_ifu[i]) begin
         if ($urandom_range(7) == 0) ifu_v[i] = 0;
      end else begin
         ifu_v[i] = 1'($urandom_range(1));
         ifu_a[i] = $urandom;
      end
      if (lsu_v[i] && !hs_lsu[i]) begin
         if ($urandom_range(7) == 0) lsu_v[i] = 0;
      end else begin
         lsu_v[i]  = 1'($urandom_range(1));
         lsu_we[i] = 1'($urandom_range(1));
         lsu_sz[i] = 2'($urandom_range(3));
         lsu_a[i]  = $urandom;
         lsu_wd[i] = $urandom;
      end
      hs_ifu[i] = 0; hs_lsu[i] = 0;
   endtask

   initial begin
      int base, snap, snap2;
      logic [31:0] sampled;
      for (int i = 0; i < 2; i++) begin
         busy[i] = 0; t_hs[i] = -100; own_lsu[i] = 0; lg_lsu[i] = 0;
         e_addr[i] = '0; e_wd[i] = '0; e_we[i] = 0; e_sz[i] = '0; cap[i] = '0;
         ifu_hold[i] = '0; lsu_hold[i] = '0; hs_ifu[i] = 0; hs_lsu[i] = 0;
         rd_fix[i] = 0; mrd[i] = '0;
         obs_ifu_hs[i] = 0; obs_mreq[i] = 0; obs_ifu_rv[i] = 0;
      end
      do_reset();

      // IFU-only fetch with a fixed instruction word on the memory bus
      rd_fix[0] = 1; mrd[0] = 32'h0010_0093;
      ifu_a[0] = 32'h8000_0000; ifu_v[0] = 1;
      wait_hs(0, 0);
      repeat (3) tick();
      chk("ifu_fetch_data", 0, ifu_rd[0], 32'h0010_0093);
      rd_fix[0] = 0;

      // LSU store: response carries zero data
      lsu_a[0] = 32'h8000_1000; lsu_wd[0] = 32'hDEAD_BEEF; lsu_sz[0] = 2'b10;
      lsu_we[0] = 1; lsu_v[0] = 1;
      wait_hs(0, 1);
      repeat (4) tick();
      chk("store_rdata_zero", 0, lsu_rd[0], 32'h0);

      // Both requesters held after reset: LSU, IFU, LSU at cycles 0, 4, 8
      do_reset();
      g_cyc.delete(); g_lsu.delete();
      base = cyc;
      ifu_a[0] = 32'h8000_0100; lsu_a[0] = 32'h8000_2000; lsu_we[0] = 0;
      lsu_sz[0] = 2'b01; ifu_v[0] = 1; lsu_v[0] = 1;
      repeat (12) tick();
      ifu_v[0] = 0; lsu_v[0] = 0;
      chk("tie_grant_count", 0, g_cyc.size(), 3);
      while (g_cyc.size() < 3) begin g_cyc.push_back(-1); g_lsu.push_back(1'b0); end
      chk("tie_g0_lsu", 0, g_lsu[0], 1'b1);
      chk("tie_g1_ifu", 0, g_lsu[1], 1'b0);
      chk("tie_g2_lsu", 0, g_lsu[2], 1'b1);
      chk("tie_g0_cycle", 0, g_cyc[0] - base, 0);
      chk("tie_g1_cycle", 0, g_cyc[1] - base, 4);
      chk("tie_g2_cycle", 0, g_cyc[2] - base, 8);
      repeat (2) tick();

      // LATENCY=4 load: data sampled at T+5, shown at T+6
      lsu_a[1] = 32'h8000_0010; lsu_we[1] = 0; lsu_sz[1] = 2'b10; lsu_v[1] = 1;
      wait_hs(1, 1);
      repeat (4) tick();
      sampled = mrd[1];
      repeat (3) tick();
      chk("lat4_load_data", 1, lsu_rd[1], sampled);

      // Reset during WAIT drops the access
      ifu_a[1] = 32'h8000_0040; ifu_v[1] = 1;
      wait_hs(1, 0);
      repeat (2) tick();
      snap = obs_ifu_rv[1];
      do_reset();
      repeat (8) tick();
      chk("no_resp_after_reset", 1, obs_ifu_rv[1] - snap, 0);
      ifu_a[1] = 32'h8000_0080; ifu_v[1] = 1;
      wait_hs(1, 0);
      repeat (7) tick();

      // IFU valid rises and falls while LSU owns the port
      snap  = obs_mreq[0];
      snap2 = obs_ifu_hs[0];
      lsu_a[0] = 32'h8000_3000; lsu_we[0] = 0; lsu_sz[0] = 2'b00; lsu_v[0] = 1;
      wait_hs(0, 1);
      ifu_a[0] = 32'h8000_0200; ifu_v[0] = 1;
      repeat (2) tick();
      ifu_v[0] = 0;
      repeat (5) tick();
      chk("withdrawn_mem_req_count", 0, obs_mreq[0] - snap, 1);
      chk("withdrawn_ifu_handshakes", 0, obs_ifu_hs[0] - snap2, 0);

      // Randomized traffic on both latencies
      for (int n = 0; n < 600; n++) begin
         rand_drive(0);
         rand_drive(1);
         tick();
      end
      clear_inputs();
      repeat (8) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
